// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default geometry and Gray/binary pointer conversion.
// The conversion functions operate on a 32-bit container; callers zero-extend
// their pointer into it and truncate the result back to their own width, so one
// pair of functions serves any pointer width up to 32 bits.
package fifo_pkg;

    localparam int unsigned FIFO_P_SIZE = 4;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned FIFO_FN_W   = 32;

    // Binary to reflected Gray code.
    function automatic logic [FIFO_FN_W-1:0] bin2gray(input logic [FIFO_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FIFO_FN_W-1:0] gray2bin(input logic [FIFO_FN_W-1:0] g);
        logic [FIFO_FN_W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < FIFO_FN_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO controller.
//   slave  : the write controller (takes requests and read pointer, drives flags)
//   master : the producer / surrounding logic
interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned P_SIZE = FIFO_P_SIZE
) ();

    logic              w_inc;
    logic [P_SIZE-1:0] r_gptr;
    logic              w_ovf_clr;
    logic [P_SIZE-2:0] w_addr;
    logic [P_SIZE-1:0] w_gptr;
    logic              w_full;
    logic              w_afull;
    logic [P_SIZE-1:0] w_level;
    logic              w_ovf;

    modport slave (
        input  w_inc, r_gptr, w_ovf_clr,
        output w_addr, w_gptr, w_full, w_afull, w_level, w_ovf
    );

    modport master (
        output w_inc, r_gptr, w_ovf_clr,
        input  w_addr, w_gptr, w_full, w_afull, w_level, w_ovf
    );

endinterface

// File: rtl/fifo_ptr_sync.sv
// N-stage flop synchronizer for a Gray-coded pointer, async reset to 0.
//   clk, rst_n : destination clock and active-low async reset
//   d          : pointer from the foreign clock domain
//   q          : synchronized pointer (last stage)
module fifo_ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift chain; stage 0 is the only flop that samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: binary/Gray write pointer, memory
// write address, full / almost-full / level flags and sticky overflow.
//   w_clk, w_rstn : write clock, active-low async reset
//   bus (slave)   : w_inc, r_gptr, w_ovf_clr in; w_addr, w_gptr, w_full,
//                   w_afull, w_level, w_ovf out (all outputs registered)
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned P_SIZE      = FIFO_P_SIZE,
    parameter int unsigned F_DEPTH     = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL    = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          w_clk,
    input  logic          w_rstn,
    fifo_wr_ctrl_if.slave bus
);

    if (F_DEPTH != (1 << (P_SIZE - 1))) begin : g_bad_depth
        $error("fifo_wr_ctrl: F_DEPTH must equal 2**(P_SIZE-1)");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be at least 2");
    end

    logic [P_SIZE-1:0] wbin;
    logic [P_SIZE-1:0] wgray;
    logic [P_SIZE-1:0] level_q;
    logic              full_q;
    logic              afull_q;
    logic              ovf_q;

    logic [P_SIZE-1:0] rq_s;
    logic [P_SIZE-1:0] rbin_s;
    logic [P_SIZE-1:0] wbin_n;
    logic [P_SIZE-1:0] wgray_n;
    logic [P_SIZE-1:0] level_n;
    logic [P_SIZE-1:0] full_cmp;
    logic              wen;

    // Read Gray pointer brought into w_clk.
    fifo_ptr_sync #(
        .WIDTH  (P_SIZE),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (w_rstn),
        .d     (bus.r_gptr),
        .q     (rq_s)
    );

    // Next-pointer and flag terms; flags are evaluated on the post-write pointer
    // so a write that fills the last slot raises w_full on the same edge.
    always_comb begin
        wen      = bus.w_inc && !full_q;
        wbin_n   = wbin + P_SIZE'(wen);
        wgray_n  = P_SIZE'(bin2gray(FIFO_FN_W'(wbin_n)));
        rbin_s   = P_SIZE'(gray2bin(FIFO_FN_W'(rq_s)));
        level_n  = wbin_n - rbin_s;
        full_cmp = {~rq_s[P_SIZE-1:P_SIZE-2], rq_s[P_SIZE-3:0]};
    end

    // Pointer, flag and overflow registers; overflow set takes priority over clear.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            wbin    <= '0;
            wgray   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin    <= wbin_n;
            wgray   <= wgray_n;
            level_q <= level_n;
            full_q  <= (wgray_n == full_cmp);
            afull_q <= (level_n >= P_SIZE'(AF_LEVEL));
            if (bus.w_inc && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.w_ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.w_addr  = wbin[P_SIZE-2:0];
    assign bus.w_gptr  = wgray;
    assign bus.w_full  = full_q;
    assign bus.w_afull = afull_q;
    assign bus.w_level = level_q;
    assign bus.w_ovf   = ovf_q;

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain controller of the asynchronous FIFO. It sits directly upstream of the FIFO memory and produces the write address and the full flag that gate memory writes. It also generates the Gray-coded write pointer exported to the read domain, and synchronizes the read domain's Gray pointer into `w_clk`. On top of the basic full flag it provides fill level, almost-full, and a sticky overflow flag.

## Interface
- `P_SIZE`, default 4: pointer width, including the wrap bit.
- `F_DEPTH`, default 8: FIFO depth. Must equal 2^(P_SIZE-1).
- `AF_LEVEL`, default 6: almost-full threshold in entries, 1..F_DEPTH.
- `SYNC_STAGES`, default 2: flop stages in the read-pointer synchronizer, ≥2.
- `w_clk` in 1: write-domain clock.
- `w_rstn` in 1: reset, asynchronous, active-low; clock `w_clk`.
- `w_inc` in 1: write request from the producer.
- `r_gptr` in P_SIZE: read Gray pointer from the read domain. Asynchronous to `w_clk`.
- `w_ovf_clr` in 1: clears `w_ovf`.
- `w_addr` out P_SIZE-1: memory write address, the low bits of the binary write pointer.
- `w_gptr` out P_SIZE: registered Gray write pointer, sent to the read-domain synchronizer.
- `w_full` out 1: FIFO full. The memory writes only when `w_inc && !w_full`.
- `w_afull` out 1: level ≥ AF_LEVEL.
- `w_level` out P_SIZE: entries currently held, as seen from the write domain (0..F_DEPTH).
- `w_ovf` out 1: sticky flag; a write was attempted while full.

## Operation
- Internal state:
  - `wbin`: P_SIZE-bit binary write pointer.
  - `wgray`: the `w_gptr` register.
  - `rq`: synchronizer chain for `r_gptr`.
  - Registers for `w_full`, `w_afull`, `w_level`, `w_ovf`.
- Reset values: all pointers 0, `w_addr`=0, `w_gptr`=0, `w_full`=0, `w_afull`=0, `w_level`=0, `w_ovf`=0, synchronizer flops 0.
- Write accept: `wen = w_inc && !w_full`.
  - Next pointer `wbin_n = wbin + wen`, modulo 2^P_SIZE, so it wraps naturally.
  - Next Gray pointer `wgray_n = wbin_n ^ (wbin_n >> 1)`.
- `w_addr = wbin[P_SIZE-2:0]`, driven directly from the register. The memory writes at the current address on the same edge at which the pointer advances.
- Read pointer in write domain:
  - `rq_s` is the last synchronizer stage.
  - `rbin_s = gray2bin(rq_s)`.
- Full flag, registered: `w_full <= (wgray_n == {~rq_s[P-1:P-2], rq_s[P-3:0]})`.
- Level, registered: `w_level <= wbin_n - rbin_s`, modulo 2^P_SIZE. Never exceeds F_DEPTH.
- Almost-full, registered: `w_afull <= (wbin_n - rbin_s) >= AF_LEVEL`.
- Overflow:
  - `w_inc && w_full` sets `w_ovf` on the next edge.
  - `w_ovf_clr` clears it.
  - Simultaneous set and clear: set wins.
- A write attempted while full is dropped: pointer unchanged, no memory write.
- The full indication is pessimistic. A read-side free becomes visible only after synchronization; no false "not full" is ever produced.
- Reset mid-operation: all state returns to reset values asynchronously. Pointers restart at 0; the read domain must be reset in the same reset event.

## Timing
- Write to `w_full`: a write that fills the last entry asserts `w_full` on that same edge, with no gap. The next `w_inc` is refused.
- Read free to `w_full` deassert: a change on `r_gptr` reaches `rq_s` after SYNC_STAGES `w_clk` edges. `w_full`, `w_level` and `w_afull` update on the following edge, so SYNC_STAGES+1 edges worst case after the first `w_clk` edge that samples the change.
- `w_gptr` changes at most one bit per `w_clk` cycle. It is registered with no combinational path to the output.
- `w_ovf` is set one edge after the offending cycle.

## Structure
- Shared package `fifo_pkg` holds:
  - Functions `bin2gray` and `gray2bin`, parameterized by width, reused by the read-domain controller.
  - Default constants `FIFO_P_SIZE` = 4 and `FIFO_DEPTH` = 8.
- One sub-module, `fifo_ptr_sync`: an N-stage, P_SIZE-wide flop synchronizer with reset to 0. The read-domain controller reuses it.
- The rest lives in `fifo_wr_ctrl`: pointer/Gray registers, flag logic, overflow logic.

## Test plan
- **Reset:** `w_rstn`=0 mid-burst → all outputs 0 immediately. After release with `r_gptr`=0: `w_level`=0, `w_full`=0.
- **Fill:** `r_gptr`=0, then 8 consecutive `w_inc` →
  - `w_addr` steps 0..7, then shows 0.
  - `w_level` reaches 8 and `w_gptr`=4'b1100 after the 8th edge.
  - `w_afull`=1 after the 6th write.
  - `w_full`=1 after the 8th write.
- **Overflow:** with the FIFO full, `w_inc`=1 for 2 cycles → `wbin`/`w_addr` unchanged, `w_ovf`=1. Then `w_ovf_clr` and `w_inc` together while still full → `w_ovf` stays 1. Then `w_ovf_clr` alone → `w_ovf`=0.
- **Drain visibility:** with the FIFO full, set `r_gptr`=4'b0010 (binary 3) → `w_full`=0 and `w_level`=5 exactly 3 edges later, not earlier. `w_afull`=0 on the same edge.
- **Wrap:** 40 writes interleaved with `r_gptr` advancing through the Gray sequence → check each cycle:
  - `w_gptr` Hamming distance ≤1 between consecutive values.
  - `w_level` matches the model.
  - `w_full` is never deasserted while the model level is 8.
- **Reset mid-operation:** assert `w_rstn`=0 at a random point in a random write/read mix → outputs return to reset values asynchronously, the synchronizer is cleared, and the FIFO restarts cleanly.
